// File: rtl/qcw_ocd_multi.sv
// Multi-channel QCW over-current detector: per-channel peak |current| tracking,
// consecutive over-limit counting, one-cycle halt pulse and sticky fault.

module qcw_ocd_lane #(
    parameter int ADC_WIDTH  = 10,
    parameter int TRIP_COUNT = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                 system_clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 upd,
    input  logic [ADC_WIDTH-1:0] limit,
    input  logic [ADC_WIDTH-1:0] sample,
    output logic [ADC_WIDTH-1:0] max_val,
    output logic                 over
);
    localparam logic [ADC_WIDTH-1:0] MID     = {1'b1, {(ADC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_TRIP = CNT_WIDTH'(TRIP_COUNT - 1);

    logic [ADC_WIDTH-1:0] abs_val;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 hit;

    // Offset-binary distance from mid-scale; tops out at MID, so no overflow.
    assign abs_val = (sample >= MID) ? sample - MID : MID - sample;
    assign hit     = (limit != '0) && (abs_val >= limit);
    assign over    = hit && (cnt == CNT_TRIP);

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            max_val <= '0;
            cnt     <= '0;
        end else if (clr) begin
            max_val <= '0;
            cnt     <= '0;
        end else if (upd) begin
            if (abs_val > max_val)
                max_val <= abs_val;
            if (hit)
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            else
                cnt <= '0;
        end
    end
endmodule

module qcw_ocd_multi #(
    parameter int CHANNELS   = 2,
    parameter int ADC_WIDTH  = 10,
    parameter int TRIP_COUNT = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                          system_clk,
    input  logic                          reset_n,
    input  logic                          qcw_start,
    input  logic                          qcw_done,
    input  logic [ADC_WIDTH-1:0]          ocd_limit,
    input  logic                          adc_valid,
    input  logic [CHANNELS*ADC_WIDTH-1:0] adc_dout,
    input  logic                          fault_clear,
    output logic [CHANNELS*ADC_WIDTH-1:0] current_max,
    output logic                          qcw_halt,
    output logic                          fault_latched,
    output logic [CHANNELS-1:0]           trip_channel,
    output logic                          busy
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                              state;
    logic [ADC_WIDTH-1:0]                limit;
    logic [CHANNELS-1:0][ADC_WIDTH-1:0]  samples;
    logic [CHANNELS-1:0][ADC_WIDTH-1:0]  max_vals;
    logic [CHANNELS-1:0]                 over;
    logic                                lane_clr;
    logic                                lane_upd;

    assign samples     = adc_dout;
    assign current_max = max_vals;
    assign lane_clr    = (state == IDLE) && qcw_start;
    assign lane_upd    = (state == RUN) && adc_valid;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        qcw_ocd_lane #(
            .ADC_WIDTH (ADC_WIDTH),
            .TRIP_COUNT(TRIP_COUNT),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_lane (
            .system_clk(system_clk),
            .reset_n   (reset_n),
            .clr       (lane_clr),
            .upd       (lane_upd),
            .limit     (limit),
            .sample    (samples[i]),
            .max_val   (max_vals[i]),
            .over      (over[i])
        );
    end

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            limit         <= '0;
            qcw_halt      <= 1'b0;
            fault_latched <= 1'b0;
            trip_channel  <= '0;
            busy          <= 1'b0;
        end else begin
            qcw_halt <= 1'b0;
            // A trip later in this block overrides the clear.
            if (fault_clear)
                fault_latched <= 1'b0;
            case (state)
                IDLE: begin
                    if (qcw_start) begin
                        limit        <= ocd_limit;
                        trip_channel <= '0;
                        state        <= RUN;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (adc_valid && |over) begin
                        qcw_halt      <= 1'b1;
                        fault_latched <= 1'b1;
                        trip_channel  <= over;
                        state         <= HALT;
                    end else if (qcw_start || qcw_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HALT: begin
                    if (qcw_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qcw_ocd_multi.sv
// Directed bench for qcw_ocd_multi (CHANNELS=2, ADC_WIDTH=10, TRIP_COUNT=2).

module tb_qcw_ocd_multi;
    logic        system_clk;
    logic        reset_n;
    logic        qcw_start;
    logic        qcw_done;
    logic [9:0]  ocd_limit;
    logic        adc_valid;
    logic [19:0] adc_dout;
    logic        fault_clear;
    logic [19:0] current_max;
    logic        qcw_halt;
    logic        fault_latched;
    logic [1:0]  trip_channel;
    logic        busy;

    int total = 0;
    int bad   = 0;

    qcw_ocd_multi #(
        .CHANNELS(2), .ADC_WIDTH(10), .TRIP_COUNT(2), .CNT_WIDTH(4)
    ) dut (
        .system_clk   (system_clk),
        .reset_n      (reset_n),
        .qcw_start    (qcw_start),
        .qcw_done     (qcw_done),
        .ocd_limit    (ocd_limit),
        .adc_valid    (adc_valid),
        .adc_dout     (adc_dout),
        .fault_clear  (fault_clear),
        .current_max  (current_max),
        .qcw_halt     (qcw_halt),
        .fault_latched(fault_latched),
        .trip_channel (trip_channel),
        .busy         (busy)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    task automatic step();
        @(posedge system_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_s(input int s0, input int s1);
        logic [9:0] a;
        logic [9:0] b;
        a = 10'(s0);
        b = 10'(s1);
        adc_dout = {b, a};
    endtask

    initial begin
        reset_n = 0; qcw_start = 0; qcw_done = 0; ocd_limit = 0;
        adc_valid = 0; fault_clear = 0;
        set_s(512, 512);
        step(); step();
        chk("rst_halt", 32'(qcw_halt), 0);
        chk("rst_fault", 32'(fault_latched), 0);
        chk("rst_trip", 32'(trip_channel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_max", 32'(current_max), 0);
        reset_n = 1;
        step();

        // T1: two consecutive over-limit samples on ch0 trip.
        ocd_limit = 100; qcw_start = 1; adc_valid = 1; set_s(612, 512);
        step();
        qcw_start = 0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_start_sample_ignored", 32'(current_max[9:0]), 0);
        step();
        chk("t1_no_halt_first", 32'(qcw_halt), 0);
        chk("t1_max_first", 32'(current_max[9:0]), 100);
        step();
        chk("t1_halt", 32'(qcw_halt), 1);
        chk("t1_trip", 32'(trip_channel), 1);
        chk("t1_fault", 32'(fault_latched), 1);
        chk("t1_max", 32'(current_max[9:0]), 100);
        adc_valid = 0;
        step();
        chk("t1_halt_one_cycle", 32'(qcw_halt), 0);
        chk("t1_busy_halt", 32'(busy), 1);
        qcw_done = 1;
        step();
        qcw_done = 0;
        chk("t1_idle", 32'(busy), 0);
        chk("t1_trip_held", 32'(trip_channel), 1);
        chk("t1_max_held", 32'(current_max[9:0]), 100);
        fault_clear = 1;
        step();
        fault_clear = 0;
        chk("t1_fault_cleared", 32'(fault_latched), 0);

        // T2: intervening under-limit sample resets the run.
        qcw_start = 1;
        step();
        qcw_start = 0;
        chk("t2_trip_cleared", 32'(trip_channel), 0);
        adc_valid = 1;
        set_s(612, 512); step(); chk("t2_a", 32'(qcw_halt), 0);
        set_s(600, 512); step(); chk("t2_b", 32'(qcw_halt), 0);
        set_s(612, 512); step(); chk("t2_c", 32'(qcw_halt), 0);
        adc_valid = 0; qcw_done = 1;
        step();
        qcw_done = 0;
        chk("t2_busy", 32'(busy), 0);
        chk("t2_max", 32'(current_max[9:0]), 100);
        chk("t2_fault", 32'(fault_latched), 0);

        // T3: both channels over, invalid gaps do not reset counters.
        qcw_start = 1;
        step();
        qcw_start = 0;
        adc_valid = 1; set_s(612, 412);
        step();
        adc_valid = 0; set_s(512, 512);
        step(); chk("t3_gap1", 32'(qcw_halt), 0);
        step(); chk("t3_gap2", 32'(qcw_halt), 0);
        adc_valid = 1; set_s(612, 412);
        step();
        adc_valid = 0;
        chk("t3_halt", 32'(qcw_halt), 1);
        chk("t3_trip", 32'(trip_channel), 3);
        chk("t3_max0", 32'(current_max[9:0]), 100);
        chk("t3_max1", 32'(current_max[19:10]), 100);
        qcw_done = 1; step(); qcw_done = 0;
        fault_clear = 1; step(); fault_clear = 0;

        // T4: limit 0 disables detection but peaks still tracked.
        ocd_limit = 0; qcw_start = 1;
        step();
        qcw_start = 0;
        adc_valid = 1; set_s(0, 1023);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_no_halt", 32'(qcw_halt), 0);
        end
        adc_valid = 0;
        chk("t4_max0", 32'(current_max[9:0]), 512);
        chk("t4_max1", 32'(current_max[19:10]), 511);
        chk("t4_fault", 32'(fault_latched), 0);
        qcw_done = 1; step(); qcw_done = 0;

        // T5: trip coincident with qcw_done still halts.
        ocd_limit = 100; qcw_start = 1;
        step();
        qcw_start = 0;
        adc_valid = 1; set_s(612, 512);
        step();
        qcw_done = 1;
        step();
        qcw_done = 0;
        chk("t5_halt", 32'(qcw_halt), 1);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_trip", 32'(trip_channel), 1);
        set_s(1023, 512);
        step();
        chk("t5_halt_off", 32'(qcw_halt), 0);
        chk("t5_max_frozen", 32'(current_max[9:0]), 100);
        chk("t5_still_halt", 32'(busy), 1);
        adc_valid = 0; qcw_done = 1;
        step();
        qcw_done = 0;
        chk("t5_idle", 32'(busy), 0);
        chk("t5_fault_sticky", 32'(fault_latched), 1);
        fault_clear = 1; step(); fault_clear = 0;
        chk("t5_fault_clear", 32'(fault_latched), 0);

        // T6: async reset mid-burst, then a fresh burst needs two samples again.
        qcw_start = 1;
        step();
        qcw_start = 0;
        adc_valid = 1; set_s(612, 512);
        step();
        adc_valid = 0;
        #2 reset_n = 0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_max", 32'(current_max), 0);
        chk("t6_rst_halt", 32'(qcw_halt), 0);
        #2 reset_n = 1;
        step();
        chk("t6_no_halt_pulse", 32'(qcw_halt), 0);
        qcw_start = 1;
        step();
        qcw_start = 0;
        adc_valid = 1; set_s(612, 512);
        step();
        adc_valid = 0;
        chk("t6_one_sample", 32'(qcw_halt), 0);
        step();
        chk("t6_no_trip", 32'(qcw_halt), 0);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_fault", 32'(fault_latched), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
